// File: rtl/button_debounce_if.sv
// Push-button signal bundle: raw pin toward the debouncer, conditioned level and pulses back.
interface button_debounce_if;
  logic btn_raw;
  logic button;
  logic pressed;
  logic released;
  logic long_press;

  modport master (
    output btn_raw,
    input  button,
    input  pressed,
    input  released,
    input  long_press
  );

  modport slave (
    input  btn_raw,
    output button,
    output pressed,
    output released,
    output long_press
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-count debouncer, registered
// press/release/long-press pulses.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LONG_CYCLES     = 20,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  button_debounce_if.slave bus
);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
    $error("button_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  localparam logic [CNT_WIDTH-1:0] DbLast   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LongMax  = CNT_WIDTH'(LONG_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LongLast = CNT_WIDTH'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    SReleased,
    SPressChk,
    SPressed,
    SReleaseChk
  } state_e;

  state_e               state_q, state_d;
  logic                 sync0_q, sync1_q;
  logic                 pin_lvl;
  logic [CNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                 button_q, button_d;
  logic                 pressed_q, pressed_d;
  logic                 released_q, released_d;
  logic                 long_q, long_d;

  // Normalise polarity so that 1 always means "pressed" downstream.
  assign pin_lvl = bus.btn_raw ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= pin_lvl;
      sync1_q <= sync0_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SReleased;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      button_q   <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      button_q   <= button_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      long_q     <= long_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    button_d   = button_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    long_d     = 1'b0;

    // Hold counter runs for the whole accepted press, bounces included, and saturates.
    if (button_q && (hold_cnt_q < LongMax)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      long_d     = (hold_cnt_q == LongLast);
    end

    unique case (state_q)
      SReleased: begin
        if (sync1_q) begin
          state_d  = SPressChk;
          db_cnt_d = '0;
        end
      end
      SPressChk: begin
        if (!sync1_q) begin
          state_d = SReleased;
        end else if (db_cnt_q == DbLast) begin
          state_d    = SPressed;
          button_d   = 1'b1;
          pressed_d  = 1'b1;
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      SPressed: begin
        if (!sync1_q) begin
          state_d  = SReleaseChk;
          db_cnt_d = '0;
        end
      end
      SReleaseChk: begin
        if (sync1_q) begin
          state_d = SPressed;
        end else if (db_cnt_q == DbLast) begin
          state_d    = SReleased;
          button_d   = 1'b0;
          released_d = 1'b1;
          // Release takes priority over a coincident long-press threshold.
          long_d     = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = SReleased;
    endcase
  end

  assign bus.button     = button_q;
  assign bus.pressed    = pressed_q;
  assign bus.released   = released_q;
  assign bus.long_press = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: an active-high and an active-low instance share one raw stimulus
// and are checked every cycle against a run-length model, plus directed edge-timing checks.
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic raw   = 1'b0;
  bit   cmp_en = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  button_debounce_if bif_a ();
  button_debounce_if bif_b ();
  assign bif_a.btn_raw = raw;
  assign bif_b.btn_raw = ~raw;

  button_debounce #(
    .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .CNT_WIDTH(16), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bif_a.slave)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .CNT_WIDTH(16), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bif_b.slave)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] exp);
    vecs++;
    if (actual !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, exp, $time);
    end
  endtask

  // Model: the level flips once the synchronised pin has disagreed with it for D+1 straight
  // edges; long press fires L edges after the press edge unless the release lands there.
  bit m_p0, m_p1, m_button, m_pressed, m_released, m_long;
  int m_run, m_age;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_p0 <= 0; m_p1 <= 0; m_button <= 0; m_pressed <= 0; m_released <= 0; m_long <= 0;
      m_run <= 0; m_age <= 0;
    end else begin
      automatic int run = (m_p1 != m_button) ? m_run + 1 : 0;
      automatic int age = m_age;
      automatic bit b = m_button;
      automatic bit p = 0;
      automatic bit r = 0;
      automatic bit lp = 0;
      if (run == D + 1) begin
        run = 0;
        if (!b) begin
          b = 1; p = 1; age = 0;
        end else begin
          b = 0; r = 1;
        end
      end else if (b && age < L) begin
        age++;
        lp = (age == L);
      end
      m_p0 <= raw; m_p1 <= m_p0;
      m_run <= run; m_age <= age;
      m_button <= b; m_pressed <= p; m_released <= r; m_long <= lp;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("model_a", {28'd0, bif_a.button, bif_a.pressed, bif_a.released, bif_a.long_press},
            {28'd0, m_button, m_pressed, m_released, m_long});
      check("model_b", {28'd0, bif_b.button, bif_b.pressed, bif_b.released, bif_b.long_press},
            {28'd0, m_button, m_pressed, m_released, m_long});
    end
  end

  // Call at a negedge; raw goes high for edge 1, then follows the given edge indices.
  // Logs the edge index of each pulse seen on both instances.
  task automatic run_seq(input int fall1, input int rise, input int fall2, input int total,
                         output int pe, output int re, output int le,
                         output int pc, output int rc, output int lc,
                         output int pe_b, output int re_b);
    pe = -1; re = -1; le = -1; pc = 0; rc = 0; lc = 0; pe_b = -1; re_b = -1;
    raw = 1'b1;
    for (int i = 1; i <= total; i++) begin
      @(negedge clk);
      if (bif_a.pressed)    begin pc++; pe = i; end
      if (bif_a.released)   begin rc++; re = i; end
      if (bif_a.long_press) begin lc++; le = i; end
      if (bif_b.pressed)  pe_b = i;
      if (bif_b.released) re_b = i;
      if (i == fall1) raw = 1'b0;
      if (i == rise)  raw = 1'b1;
      if (i == fall2) raw = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    raw = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pe, re, le, pc, rc, lc, pe_b, re_b;
    raw = 1'b1;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs_a", {bif_a.button, bif_a.pressed, bif_a.released, bif_a.long_press}, 0);
    check("reset_outs_b", {bif_b.button, bif_b.pressed, bif_b.released, bif_b.long_press}, 0);
    cmp_en = 1'b1;

    // Held through reset: re-detected as a fresh press.
    reset = 1'b0;
    run_seq(-1, -1, -1, 12, pe, re, le, pc, rc, lc, pe_b, re_b);
    check("held_press_edge", pe, 7);
    check("held_press_count", pc, 1);
    check("held_no_release", rc, 0);
    check("held_button", bif_a.button, 1);
    idle(20);

    // Short glitch rejected.
    run_seq(3, -1, -1, 20, pe, re, le, pc, rc, lc, pe_b, re_b);
    check("glitch_no_press", pc, 0);
    check("glitch_no_release", rc, 0);
    check("glitch_button", bif_a.button, 0);

    // Short press, both polarities.
    run_seq(12, -1, -1, 30, pe, re, le, pc, rc, lc, pe_b, re_b);
    check("short_press_edge", pe, 7);
    check("short_release_edge", re, 19);
    check("short_release_count", rc, 1);
    check("short_no_long", lc, 0);
    check("short_press_edge_b", pe_b, 7);
    check("short_release_edge_b", re_b, 19);

    // Long press: one pulse at edge 27.
    run_seq(40, -1, -1, 60, pe, re, le, pc, rc, lc, pe_b, re_b);
    check("long_press_edge", pe, 7);
    check("long_edge", le, 27);
    check("long_count", lc, 1);
    check("long_release_edge", re, 47);

    // Release bounce rejected, later clean release accepted.
    run_seq(15, 17, 27, 45, pe, re, le, pc, rc, lc, pe_b, re_b);
    check("bounce_release_edge", re, 34);
    check("bounce_release_count", rc, 1);
    check("bounce_long_edge", le, 27);

    // Release acceptance coincides with long-press threshold: release wins.
    run_seq(20, -1, -1, 40, pe, re, le, pc, rc, lc, pe_b, re_b);
    check("tie_release_edge", re, 27);
    check("tie_no_long", lc, 0);

    // Async reset between edges while pressed.
    raw = 1'b1;
    repeat (10) @(negedge clk);
    check("pre_reset_button", bif_a.button, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_a", {bif_a.button, bif_a.pressed, bif_a.released, bif_a.long_press}, 0);
    check("async_reset_b", {bif_b.button, bif_b.pressed, bif_b.released, bif_b.long_press}, 0);
    @(negedge clk);
    raw = 1'b0;
    reset = 1'b0;
    idle(5);

    // Random runs with occasional async resets, checked against the model every cycle.
    for (int k = 0; k < 250; k++) begin
      int len;
      raw = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
      repeat (len) @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    idle(20);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
